// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive control path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int DATA_W_DEF = 8;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  // Wide enough for data bits plus the parity/stop overrun (max 11).
  localparam int BIT_W = 4;

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Oversample edge counter and bit counter for the UART receive FSM.
// edge_cnt is held at 0 while disabled; clear only affects bit_cnt.
module uart_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc_q,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               bit_end
);

  logic [PRESC_W-1:0] last_edge;

  assign last_edge = presc_q - PRESC_W'(1);
  assign bit_end   = enable && (edge_cnt == last_edge);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (!enable || bit_end) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + PRESC_W'(1);
      end

      if (clear) begin
        bit_cnt <= '0;
      end else if (bit_end) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control FSM: start detect, bit timing and checker strobes.
// Optional UART_RX_ERR_CNT_EN adds err_clr/err_cnt, a saturating frame-error count.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               par_en,
  input  logic               start_error,
  input  logic               par_error,
  input  logic               stop_error,
`ifdef UART_RX_ERR_CNT_EN
  input  logic               err_clr,
  output logic [7:0]         err_cnt,
`endif
  output logic               sample_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic               start_check_en,
  output logic               deser_en,
  output logic               par_check_en,
  output logic               stop_check_en,
  output logic               data_valid,
  output logic               par_err_o,
  output logic               stop_err_o
);

  rx_state_e          state_q, state_d;
  logic [PRESC_W-1:0] presc_q;
  logic               par_err_q, par_err_d;
  logic [BIT_W-1:0]   bit_cnt;
  logic               bit_end;
  logic               strobe_pt;
  logic               last_bit;
  logic               start_det;

  assign start_det = (state_q == ST_IDLE) && !rx_in;
  assign last_bit  = (bit_cnt == BIT_W'(DATA_W - 1));
  assign strobe_pt = (edge_cnt == (presc_q - PRESC_W'(2)));

  // bit_cnt is held clear until DATA is entered.
  uart_edge_bit_counter #(
    .PRESC_W (PRESC_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .enable   (state_q != ST_IDLE),
    .clear    ((state_q == ST_IDLE) || (state_q == ST_START)),
    .presc_q  (presc_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= PRESC_W'(PRESC_8);
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      par_err_q <= par_err_d;
      if (start_det) begin
        presc_q <= prescale;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    par_err_d = par_err_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_in) state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) state_d = start_error ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && last_bit) state_d = par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (bit_end) begin
          par_err_d = par_error;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          par_err_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        par_err_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    sample_en      = (state_q != ST_IDLE);
    start_check_en = (state_q == ST_START)  && strobe_pt;
    deser_en       = (state_q == ST_DATA)   && strobe_pt;
    par_check_en   = (state_q == ST_PARITY) && strobe_pt;
    stop_check_en  = (state_q == ST_STOP)   && strobe_pt;
    data_valid     = (state_q == ST_STOP) && bit_end && !stop_error && !par_err_q;
    par_err_o      = (state_q == ST_STOP) && bit_end && par_err_q;
    stop_err_o     = (state_q == ST_STOP) && bit_end && stop_error;
  end

`ifdef UART_RX_ERR_CNT_EN
  logic err_evt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign err_evt = ((state_q == ST_START) && bit_end && start_error) || par_err_o || stop_err_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= 8'd0;
    end else if (err_clr) begin
      err_cnt <= 8'd0;
    end else if (err_evt) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: per-frame strobe counts, timing and outcome.
module tb_uart_rx_ctrl;

  localparam int DATA_W  = 8;
  localparam int PRESC_W = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               rx_in;
  logic [PRESC_W-1:0] prescale;
  logic               par_en;
  logic               start_error, par_error, stop_error;
  logic               sample_en;
  logic [PRESC_W-1:0] edge_cnt;
  logic               start_check_en, deser_en, par_check_en, stop_check_en;
  logic               data_valid, par_err_o, stop_err_o;
`ifdef UART_RX_ERR_CNT_EN
  logic               err_clr = 1'b0;
  logic [7:0]         err_cnt;
  int                 exp_err = 0;
`endif

  logic inj_start = 1'b0, inj_par = 1'b0, inj_stop = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int outc;
    int len;
    int n_start;
    int n_deser;
    int n_par;
    int n_stop;
    int first_deser;
    int last_deser;
    int end_cyc;
    int start_edge;
  } exp_t;

  exp_t sb[$];

  uart_rx_ctrl #(
    .DATA_W  (DATA_W),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_in          (rx_in),
    .prescale       (prescale),
    .par_en         (par_en),
    .start_error    (start_error),
    .par_error      (par_error),
    .stop_error     (stop_error),
`ifdef UART_RX_ERR_CNT_EN
    .err_clr        (err_clr),
    .err_cnt        (err_cnt),
`endif
    .sample_en      (sample_en),
    .edge_cnt       (edge_cnt),
    .start_check_en (start_check_en),
    .deser_en       (deser_en),
    .par_check_en   (par_check_en),
    .stop_check_en  (stop_check_en),
    .data_valid     (data_valid),
    .par_err_o      (par_err_o),
    .stop_err_o     (stop_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({sample_en, edge_cnt, start_check_en, deser_en, par_check_en,
                stop_check_en, data_valid, par_err_o, stop_err_o});
  endfunction

  // Registered upstream checkers: error flag valid the cycle after their enable.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_error <= 1'b0;
      par_error   <= 1'b0;
      stop_error  <= 1'b0;
    end else begin
      start_error <= start_check_en & inj_start;
      par_error   <= par_check_en & inj_par;
      stop_error  <= stop_check_en & inj_stop;
    end
  end

  bit in_frame = 0;
  int cyc, o_outc, o_start, o_deser, o_par, o_stop, o_first, o_last, o_end, o_sedge;

  always @(negedge clk) begin
    if (!rst) begin
      in_frame = 0;
    end else if (sample_en) begin
      if (!in_frame) begin
        in_frame = 1;
        cyc = 0; o_outc = 0; o_start = 0; o_deser = 0; o_par = 0; o_stop = 0;
        o_first = -1; o_last = -1; o_end = -1; o_sedge = -1;
      end
      if (start_check_en) begin o_start++; o_sedge = int'(edge_cnt); end
      if (deser_en) begin
        if (o_deser == 0) o_first = cyc;
        o_last = cyc;
        o_deser++;
      end
      if (par_check_en) o_par++;
      if (stop_check_en) o_stop++;
      if (data_valid || par_err_o || stop_err_o) begin
        o_outc = o_outc | int'({data_valid, par_err_o, stop_err_o});
        o_end  = cyc;
      end
      cyc++;
    end else if (in_frame) begin
      in_frame = 0;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("outcome",     o_outc,  e.outc);
        check("frame_len",   cyc,     e.len);
        check("n_start_chk", o_start, e.n_start);
        check("n_deser",     o_deser, e.n_deser);
        check("n_par_chk",   o_par,   e.n_par);
        check("n_stop_chk",  o_stop,  e.n_stop);
        check("first_deser", o_first, e.first_deser);
        check("last_deser",  o_last,  e.last_deser);
        check("end_cycle",   o_end,   e.end_cyc);
        check("start_edge",  o_sedge, e.start_edge);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (sample_en && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input int p, input int p_mid,
                            input logic pe, input logic is, input logic ip,
                            input logic ist, input bit to_idle);
    exp_t e;
    bit   perr;
    perr = pe && ip;
    e.start_edge = p - 2;
    e.n_start    = 1;
    if (is) begin
      e.len = p; e.n_deser = 0; e.n_par = 0; e.n_stop = 0;
      e.first_deser = -1; e.last_deser = -1; e.end_cyc = -1; e.outc = 0;
    end else begin
      e.len = (2 + DATA_W + int'(pe)) * p;
      e.n_deser = DATA_W; e.n_par = int'(pe); e.n_stop = 1;
      e.first_deser = 2 * p - 2;
      e.last_deser  = e.first_deser + (DATA_W - 1) * p;
      e.end_cyc = e.len - 1;
      e.outc = int'({!perr && !ist, perr, ist});
    end
`ifdef UART_RX_ERR_CNT_EN
    if (is || perr || ist) exp_err++;
`endif
    sb.push_back(e);
    prescale  = PRESC_W'(p);
    par_en    = pe;
    inj_start = is;
    inj_par   = ip;
    inj_stop  = ist;
    rx_in     = 1'b0;
    if (is) begin
      repeat (2) @(negedge clk);
      rx_in = 1'b1;
    end else begin
      repeat (p) @(negedge clk);
      for (int i = 0; i < DATA_W; i++) begin
        rx_in = d[i];
        repeat (p) @(negedge clk);
        if (i == 2) prescale = PRESC_W'(p_mid);
      end
      if (pe) begin
        rx_in = ^d ^ ip;
        repeat (p) @(negedge clk);
      end
      rx_in = 1'b1;
      repeat (p) @(negedge clk);
    end
    if (to_idle) wait_idle();
  endtask

  initial begin
    rst = 1'b0; rx_in = 1'b1; prescale = PRESC_W'(8); par_en = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", out_vec(), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", out_vec(), 32'd0);

    send_frame(8'hA5, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1);   // clean frame at 8
    send_frame(8'h00, 8, 8, 1'b0, 1'b1, 1'b0, 1'b0, 1);   // start glitch
    send_frame(8'h5A, 16, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1); // parity error
    send_frame(8'hC3, 8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1);   // stop error
    send_frame(8'h96, 32, 32, 1'b1, 1'b0, 1'b0, 1'b0, 1); // clean with parity
    send_frame(8'h3F, 16, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1); // parity and stop error

    // Reset in the middle of data bit 3.
    prescale = PRESC_W'(8); par_en = 1'b0;
    inj_start = 1'b0; inj_par = 1'b0; inj_stop = 1'b0;
    rx_in = 1'b0;
    repeat (36) @(negedge clk);
    check("mid_frame_active", 32'(sample_en), 32'd1);
    #2 rst = 1'b0;
    #1 check("mid_frame_reset", out_vec(), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
    exp_err = 0;
`endif
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    check("held_reset", out_vec(), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", out_vec(), 32'd0);
    send_frame(8'h3C, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // Prescale change mid-frame, then two back-to-back frames.
    send_frame(8'h81, 8, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    send_frame(8'h7E, 32, 32, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'hE7, 32, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    check("sb_drained", 32'(sb.size()), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", 32'(err_cnt), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
